// File: rtl/mul_ctrl_fsm.sv
// Sequencing controller for the byte-sliced RV32M multiplier datapath: one
// operand-load cycle, four rotate/accumulate steps, then a result hold until
// the core consumes it. Define MUL_PERF_CNT_EN to add a completed-operation
// counter on perf_cnt_o; otherwise that port is tied to zero.
module mul_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       funct3_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             reg_a_en_o,
  output logic             reg_b_en_o,
  output logic             mux_b_sel_o,
  output logic             rol_en_o,
  output logic             ac_en_o,
  output logic             ac_clr_o,
  output logic             signed_a_o,
  output logic [3:0]       sig_ctrl_b_o,
  output logic [2:0]       shift_0_o,
  output logic [2:0]       shift_1_o,
  output logic [2:0]       shift_2_o,
  output logic [2:0]       shift_3_o,
  output logic             upper_o,
  output logic [CNT_W-1:0] perf_cnt_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP0 = 3'd1,
    STEP1 = 3'd2,
    STEP2 = 3'd3,
    STEP3 = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic       in_step;
  logic [1:0] step_k;
  logic       upper, signed_a, signed_b;
  logic       unused_funct3;

  assign unused_funct3 = funct3_i[2];

  assign upper    = (op_q != 2'b00);
  assign signed_a = (op_q == 2'b01) || (op_q == 2'b10);
  assign signed_b = (op_q == 2'b01);

  // Lane i carries B byte (i-k) mod 4 after k rotations; its weight is i+j bytes.
  function automatic logic [2:0] lane_shift(input logic [1:0] k, input logic [1:0] lane);
    logic [1:0] j;
    j = lane - k;
    return {1'b0, lane} + {1'b0, j};
  endfunction

  always_comb begin
    in_step = 1'b1;
    step_k  = 2'd0;
    unique case (state_q)
      STEP0:   step_k = 2'd0;
      STEP1:   step_k = 2'd1;
      STEP2:   step_k = 2'd2;
      STEP3:   step_k = 2'd3;
      default: in_step = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    reg_a_en_o   = 1'b0;
    reg_b_en_o   = 1'b0;
    mux_b_sel_o  = 1'b0;
    rol_en_o     = 1'b0;
    ac_en_o      = 1'b0;
    ac_clr_o     = 1'b0;
    signed_a_o   = 1'b0;
    sig_ctrl_b_o = 4'b0000;
    shift_0_o    = 3'd0;
    shift_1_o    = 3'd0;
    shift_2_o    = 3'd0;
    shift_3_o    = 3'd0;
    upper_o      = 1'b0;

    if (in_step) begin
      signed_a_o   = signed_a;
      shift_0_o    = lane_shift(step_k, 2'd0);
      shift_1_o    = lane_shift(step_k, 2'd1);
      shift_2_o    = lane_shift(step_k, 2'd2);
      shift_3_o    = lane_shift(step_k, 2'd3);
      // The sign-carrying B byte 3 sits in lane (3+k) mod 4.
      sig_ctrl_b_o = signed_b ? (4'b0001 << (step_k + 2'd3)) : 4'b0000;
      if (kill_i) begin
        state_d = IDLE;
      end else begin
        ac_en_o = 1'b1;
        if (step_k != 2'd3) begin
          reg_b_en_o  = 1'b1;
          mux_b_sel_o = 1'b1;
          rol_en_o    = 1'b1;
        end
        unique case (state_q)
          STEP0:   state_d = STEP1;
          STEP1:   state_d = STEP2;
          STEP2:   state_d = STEP3;
          default: state_d = DONE;
        endcase
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_o = 1'b1;
          if (valid_i) begin
            reg_a_en_o = 1'b1;
            reg_b_en_o = 1'b1;
            ac_clr_o   = 1'b1;
            op_d       = funct3_i[1:0];
            state_d    = STEP0;
          end
        end
        DONE: begin
          upper_o = upper;
          if (kill_i) begin
            state_d = IDLE;
          end else begin
            valid_o = 1'b1;
            if (ready_i) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef MUL_PERF_CNT_EN
  logic             cnt_inc;
  logic [CNT_W-1:0] perf_cnt_q, perf_cnt_d;

  assign cnt_inc    = (state_q == DONE) && ready_i && !kill_i;
  assign perf_cnt_d = cnt_inc ? perf_cnt_q + CNT_W'(1) : perf_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_cnt_q <= '0;
    else         perf_cnt_q <= perf_cnt_d;
  end

  assign perf_cnt_o = perf_cnt_q;
`else
  assign perf_cnt_o = '0;
`endif

endmodule
